// File: rtl/status_writer_pkg.sv
// Shared definitions for the status writer.
//   state_e          : FSM states (IDLE, REQ, WRITE)
//   STATUS_LEN       : number of ASCII characters written per frame
//   IDX_W            : width of the character index
//   nibble_to_ascii  : 4-bit value to uppercase hex ASCII character
package status_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam int STATUS_LEN = 4;
  localparam int IDX_W      = 2;

  // 'A' is 8'h41, so 8'h37 + 10 lands on it.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end else begin
      return 8'h37 + {4'h0, nib};
    end
  endfunction

endpackage

// File: rtl/status_writer_hex_ascii.sv
// Nibble to ASCII converter (0-9 -> '0'-'9', A-F -> 'A'-'F').
//   nib_i   : 4-bit value
//   ascii_o : 8-bit ASCII character
module hex_ascii
  import status_writer_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] ascii_o
);

  assign ascii_o = nibble_to_ascii(nib_i);

endmodule

// File: rtl/status_writer.sv
// Writes a four-character hex status string (frame number, status byte)
// into an LCD text buffer once per vsync rising edge.
//   clk     : system clock
//   reset   : synchronous active-low reset
//   vsync   : frame sync level from the LCD driver
//   value   : status byte, captured on the vsync edge
//   gnt     : bus grant; a byte is written only in granted cycles
//   req     : bus request (high while a sequence is pending)
//   addr    : write address, BASE_ADDR + character index
//   data    : ASCII write data
//   we      : write strobe
//   busy    : FSM not idle
//   frame   : free-running vsync edge counter
//   overrun : one-cycle pulse for a vsync edge seen while busy
module status_writer
  import status_writer_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR = 12'h400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic [7:0]  value,
  input  logic        gnt,
  output logic        req,
  output logic [11:0] addr,
  output logic [7:0]  data,
  output logic        we,
  output logic        busy,
  output logic [7:0]  frame,
  output logic        overrun
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         frame_q;
  logic [7:0]         fsnap_q;
  logic [7:0]         vsnap_q;
  logic               vsync_q;
  logic               armed_q;
  logic               vs_rise;
  logic               wr_en;
  logic [3:0]         nib;
  logic [7:0]         ascii;

  // armed_q stays low after reset until vsync has been seen low, so a
  // vsync already high at reset release is not mistaken for an edge.
  assign vs_rise = vsync & ~vsync_q & armed_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      frame_q <= '0;
      fsnap_q <= '0;
      vsnap_q <= '0;
      vsync_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vsync_q <= vsync;
      if (!vsync) begin
        armed_q <= 1'b1;
      end
      if (vs_rise) begin
        frame_q <= frame_q + 8'd1;
      end
      // Snapshot only when starting a new sequence; edges while busy
      // must not disturb the characters being written.
      if (vs_rise && (state_q == ST_IDLE)) begin
        fsnap_q <= frame_q;
        vsnap_q <= value;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (vs_rise) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (gnt) begin
          state_d = ST_WRITE;
          idx_d   = '0;
        end
      end
      ST_WRITE: begin
        // Without a grant the index simply holds: the write stalls.
        if (gnt) begin
          wr_en = 1'b1;
          if (idx_q == IDX_W'(STATUS_LEN - 1)) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    nib = 4'h0;
    case (idx_q)
      2'd0:    nib = fsnap_q[7:4];
      2'd1:    nib = fsnap_q[3:0];
      2'd2:    nib = vsnap_q[7:4];
      default: nib = vsnap_q[3:0];
    endcase
  end

  hex_ascii u_hex_ascii (
    .nib_i   (nib),
    .ascii_o (ascii)
  );

  assign busy    = (state_q != ST_IDLE);
  assign req     = busy;
  assign we      = wr_en;
  assign addr    = wr_en ? (BASE_ADDR + {{(12 - IDX_W){1'b0}}, idx_q}) : 12'h000;
  assign data    = wr_en ? ascii : 8'h00;
  assign frame   = frame_q;
  assign overrun = vs_rise & busy;

endmodule

// File: tb/tb_status_writer.sv
`timescale 1ns/1ps
module tb_status_writer;

  localparam logic [11:0] BASE = 12'h400;

  logic        clk;
  logic        reset_n;
  logic        vsync;
  logic [7:0]  value;
  logic        gnt;
  logic        req;
  logic [11:0] addr;
  logic [7:0]  data;
  logic        we;
  logic        busy;
  logic [7:0]  frame;
  logic        overrun;

  int          tests = 0;
  int          fails = 0;
  logic [19:0] exp_q[$];
  int          wr_cnt = 0;
  logic [7:0]  last_d0 = 8'h00;
  bit          mon_en = 1'b0;

  status_writer #(.BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .reset   (reset_n),
    .vsync   (vsync),
    .value   (value),
    .gnt     (gnt),
    .req     (req),
    .addr    (addr),
    .data    (data),
    .we      (we),
    .busy    (busy),
    .frame   (frame),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_char(input logic [3:0] n);
    if (n <= 4'd9) return 8'h30 | {4'h0, n};
    else           return 8'h41 + ({4'h0, n} - 8'd10);
  endfunction

  task automatic push_seq(input logic [7:0] f, input logic [7:0] v);
    logic [3:0] n;
    for (int k = 0; k < 4; k++) begin
      n = (k == 0) ? f[7:4] : (k == 1) ? f[3:0] : (k == 2) ? v[7:4] : v[3:0];
      exp_q.push_back({BASE + 12'(k), exp_char(n)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Write monitor / scoreboard consumer.
  always @(negedge clk) begin
    logic [19:0] e;
    if (mon_en) begin
      if (we === 1'b1) begin
        wr_cnt++;
        if (addr == BASE) last_d0 = data;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {addr, data}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", addr, e[19:8]);
          chk("wr_data", data, e[7:0]);
        end
      end else begin
        chk("idle_bus", {we, addr, data}, 32'h0);
      end
    end
  end

  initial begin
    int ov;
    int w0;
    reset_n = 1'b0;
    vsync   = 1'b0;
    gnt     = 1'b1;
    value   = 8'h3C;

    // Reset state
    repeat (2) tick();
    mon_en = 1'b1;
    at_neg();
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame", frame, 0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();

    // First edge, gnt tied high: latency and characters 0,0,3,C
    vsync = 1'b1;
    push_seq(8'h00, 8'h3C);
    at_neg();
    chk("e0_busy", busy, 0);
    chk("e0_req", req, 0);
    tick();
    vsync = 1'b0;
    at_neg();
    chk("e1_req", req, 1);
    chk("e1_we", we, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      at_neg();
      chk("e2to5_we", we, 1);
    end
    tick();
    at_neg();
    chk("e6_req", req, 0);
    chk("e6_busy", busy, 0);
    chk("e6_frame", frame, 1);
    chk("s1_sb_empty", exp_q.size(), 0);

    // Grant withheld for 10 cycles after req rises
    value = 8'hA5;
    gnt   = 1'b0;
    tick();
    vsync = 1'b1;
    push_seq(8'h01, 8'hA5);
    tick();
    vsync = 1'b0;
    for (int i = 0; i < 10; i++) begin
      at_neg();
      chk("stall_req", req, 1);
      chk("stall_we", we, 0);
      tick();
    end
    gnt = 1'b1;
    at_neg();
    chk("grant_req", req, 1);
    chk("grant_we", we, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      at_neg();
      chk("post_stall_we", we, 1);
    end
    tick();
    at_neg();
    chk("s2_busy", busy, 0);
    chk("s2_sb_empty", exp_q.size(), 0);

    // Grant dropped mid-sequence after index 1
    value = 8'h7E;
    w0    = wr_cnt;
    tick();
    vsync = 1'b1;
    push_seq(8'h02, 8'h7E);
    tick();
    vsync = 1'b0;
    tick();
    tick();
    tick();
    gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("mid_stall_we", we, 0);
      chk("mid_stall_req", req, 1);
      tick();
    end
    gnt = 1'b1;
    at_neg();
    chk("resume_we", we, 1);
    chk("resume_addr", addr, BASE + 12'd2);
    tick();
    at_neg();
    chk("resume_we3", we, 1);
    tick();
    at_neg();
    chk("s3_busy", busy, 0);
    chk("s3_wr_count", wr_cnt - w0, 4);
    chk("s3_sb_empty", exp_q.size(), 0);

    // Second edge two cycles after the first
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    value = 8'h99;
    ov    = 0;
    vsync = 1'b1;
    push_seq(8'h00, 8'h99);
    at_neg();
    ov += int'(overrun);
    tick();
    vsync = 1'b0;
    at_neg();
    ov += int'(overrun);
    tick();
    vsync = 1'b1;
    at_neg();
    chk("ovr_pulse", overrun, 1);
    ov += int'(overrun);
    tick();
    vsync = 1'b0;
    for (int i = 0; i < 5; i++) begin
      at_neg();
      ov += int'(overrun);
      tick();
    end
    chk("ovr_count", ov, 1);
    chk("ovr_frame", frame, 2);
    chk("ovr_busy", busy, 0);
    chk("s4_sb_empty", exp_q.size(), 0);

    // Reset during the index-2 write
    value = 8'h11;
    tick();
    vsync = 1'b1;
    push_seq(8'h02, 8'h11);
    void'(exp_q.pop_back());
    tick();
    vsync = 1'b0;
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    at_neg();
    chk("abort_last_we", we, 1);
    tick();
    at_neg();
    chk("abort_req", req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_frame", frame, 0);
    chk("abort_overrun", overrun, 0);
    reset_n = 1'b1;
    chk("s5_sb_empty", exp_q.size(), 0);
    w0 = wr_cnt;
    repeat (4) tick();
    chk("abort_no_writes", wr_cnt - w0, 0);
    value = 8'h42;
    vsync = 1'b1;
    push_seq(8'h00, 8'h42);
    tick();
    vsync = 1'b0;
    repeat (6) tick();
    chk("s5b_sb_empty", exp_q.size(), 0);
    chk("s5b_frame", frame, 1);

    // vsync high across reset release must not count as an edge
    reset_n = 1'b0;
    vsync   = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      at_neg();
      chk("release_busy", busy, 0);
      tick();
    end
    chk("release_frame", frame, 0);
    vsync = 1'b0;
    tick();
    tick();

    // 256 edges: frame wraps, last sequence shows FF
    for (int i = 0; i < 256; i++) begin
      value = 8'(i) ^ 8'h5A;
      vsync = 1'b1;
      push_seq(8'(i), 8'(i) ^ 8'h5A);
      tick();
      vsync = 1'b0;
      repeat (7) tick();
    end
    chk("wrap_frame", frame, 0);
    chk("wrap_char0", last_d0, 8'h46);
    chk("s6_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
